restoring_divider: RTL
======================

Name: restoring_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse-operation companion to the Booth multiplier controller in the arithmetic lab.
- Accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per two-cycle SHIFT/SUB pair.
- Presents registered quotient and remainder with a one-cycle done pulse.
- Internally split into an FSM controller and an A/Q/M register datapath, mirroring the multiplier's control/datapath split.

Parameters:
- WIDTH, 4: operand width in bits; also the iteration count.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  WIDTH  numerator; captured on an accepted start.
- divisor  in  WIDTH  denominator; captured on an accepted start.
- quotient  out  WIDTH  registered result.
- remainder  out  WIDTH  registered result.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse; results valid from this cycle.
- div_by_zero  out  1  registered flag, updated together with done.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; A, Q, M, count cleared; quotient=0, remainder=0, busy=0, done=0, div_by_zero=0. Reset overrides everything, including mid-operation; no partial result is published.
- Datapath registers:
  - A: WIDTH+1 bits (partial remainder plus sign bit).
  - Q: WIDTH bits (dividend/quotient).
  - M: WIDTH bits (divisor).
  - count: ceil(log2(WIDTH+1)) bits.
- IDLE:
  - start=1 and divisor!=0: A=0, Q=dividend, M=divisor, count=0, clear div_by_zero; next state SHIFT.
  - start=1 and divisor==0: quotient=all ones, remainder=dividend, div_by_zero=1; next state DONE.
  - start=0: hold.
- SHIFT: {A,Q} shifted left one bit; Q[0] temporarily 0; next state SUB.
- SUB: trial T = A - {1'b0,M}, computed WIDTH+1 bits wide.
  - T sign=0: A=T, Q[0]=1.
  - T sign=1: A unchanged (restore folded into the same cycle), Q[0]=0.
  - count increments.
  - If count (pre-increment) == WIDTH-1, next state DONE and load quotient=Q (with new bit) and remainder=A[WIDTH-1:0]; otherwise next state SHIFT.
- DONE: done=1 for exactly this cycle; next state IDLE unconditionally. start in the DONE cycle is ignored.
- Latency: start sampled at end of cycle 0 → SHIFT in cycle 1 → SUB of final iteration in cycle 2*WIDTH → done high in cycle 2*WIDTH+1 (cycle 9 for WIDTH=4). Divide-by-zero: done high in cycle 1.
- busy: high in every non-IDLE state.
- start while busy: ignored, with no effect on operands or result.
- Output hold: quotient, remainder and div_by_zero hold their values until the next accepted start overwrites them at its completion. div_by_zero clears at acceptance of a non-zero-divisor start.
- Illegal state encodings: recover to IDLE on the next clock with outputs unchanged.
- Invariant after each SUB: A < M, A never negative.
- Identities at done (divisor!=0): dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared package divider_pkg holds:
  - state encoding constants IDLE=3'b000, SHIFT=3'b001, SUB=3'b010, DONE=3'b011;
  - datapath control codes LOAD, SHIFT_L, TRIAL, HOLD (2-bit), matching the multiplier's register-control code style.
- One sub-module is natural: div_datapath. It contains A/Q/M/count and the trial subtractor, and exports the T sign bit and count-terminal flag to the FSM in restoring_divider.

Test Plan:
- 13/4, WIDTH=4: start in cycle 0 → done=1 exactly in cycle 9, quotient=3, remainder=1, div_by_zero=0; busy high cycles 1–9.
- 15/1 and 3/7 back to back, second start issued first IDLE cycle after done → 15 r0, then 0 r3. Each takes 9 cycles; results from the first hold until the second's done.
- 9/0 → done in cycle 1, quotient=4'hF, remainder=9, div_by_zero=1. A following 8/2 → 4 r0 and div_by_zero=0.
- start re-pulsed with 1/1 in cycles 3 and 9 during 14/3 → ignored; result 4 r2 at cycle 9. start in the DONE cycle does not launch a new operation.
- reset asserted in cycle 5 of 12/5 → cycle 6 shows IDLE, busy=0, done=0, quotient=0, remainder=0. No done pulse follows; a new 12/5 start then completes with 2 r2.
- Exhaustive sweep of all 256 operand pairs for WIDTH=4, plus random WIDTH=8 → check dividend == q*d + r and r < d. done must pulse once per accepted start.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared encodings for the restoring divider: FSM states and datapath control codes.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    SHIFT = 3'b001,
    SUB   = 3'b010,
    DONE  = 3'b011
  } state_t;

  typedef enum logic [1:0] {
    LOAD    = 2'b00,
    SHIFT_L = 2'b01,
    TRIAL   = 2'b10,
    HOLD    = 2'b11
  } dp_ctrl_t;

endpackage

// File: rtl/div_datapath.sv
// A/Q/M/count registers plus the trial subtractor; the FSM steers it with one control code per cycle.
module div_datapath
  import divider_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  dp_ctrl_t         ctrl,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             t_neg,
  output logic             last,
  output logic [WIDTH-1:0] q_res,
  output logic [WIDTH-1:0] r_res
);

  logic [WIDTH:0]   a, t;
  logic [WIDTH-1:0] q, m;
  logic [CW-1:0]    count;

  assign t     = a - {1'b0, m};
  assign t_neg = t[WIDTH];
  assign last  = (count == CW'(WIDTH - 1));
  // Result of the SUB cycle in flight, so the FSM can publish it without an extra cycle.
  assign q_res = {q[WIDTH-1:1], ~t_neg};
  assign r_res = t_neg ? a[WIDTH-1:0] : t[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      a     <= '0;
      q     <= '0;
      m     <= '0;
      count <= '0;
    end else begin
      case (ctrl)
        LOAD: begin
          a     <= '0;
          q     <= dividend;
          m     <= divisor;
          count <= '0;
        end
        SHIFT_L: {a, q} <= {a[WIDTH-1:0], q, 1'b0};
        TRIAL: begin
          // Restore is folded in: a negative trial simply leaves A untouched.
          if (!t_neg) a <= t;
          q[0]  <= ~t_neg;
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: FSM controller driving the A/Q/M datapath.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t           state;
  dp_ctrl_t         ctrl;
  logic             t_neg, last;
  logic [WIDTH-1:0] q_res, r_res;

  always_comb begin
    ctrl = HOLD;
    case (state)
      IDLE:    if (start && divisor != '0) ctrl = LOAD;
      SHIFT:   ctrl = SHIFT_L;
      SUB:     ctrl = TRIAL;
      default: ctrl = HOLD;
    endcase
  end

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clock    (clock),
    .reset    (reset),
    .ctrl     (ctrl),
    .dividend (dividend),
    .divisor  (divisor),
    .t_neg    (t_neg),
    .last     (last),
    .q_res    (q_res),
    .r_res    (r_res)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              state       <= SHIFT;
            end
          end
        end
        SHIFT: state <= SUB;
        SUB: begin
          if (last) begin
            quotient  <= q_res;
            remainder <= r_res;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
